cla_nibble_serial_adder: RTL and testbench
==========================================

// Module: cla_nibble_serial_adder
// PURPOSE
// - Multi-cycle WIDTH-bit adder built on one 4-bit carry-lookahead slice (a + b + cin -> 4-bit sum, carry out).
// - Processes one nibble per clock, least significant nibble first, and registers the carry between nibbles.
// - Sits downstream of the operand source and drives the 4-bit CLA slice. Its valid/ready result goes to the consumer.
// - Exchanges area for latency on datapaths too wide for one combinational adder.
// PARAMETERS
// - WIDTH  default 16  operand and sum width. Must be a multiple of 4 and >= 4. NIB = WIDTH/4.
// PORTS
// - clk        in   1      clock, rising edge
// - rst        in   1      synchronous reset, active-high
// - in_valid   in   1      operands present on a, b, carry
// - in_ready   out  1      block can accept operands
// - a          in   WIDTH  addend A
// - b          in   WIDTH  addend B
// - carry      in   1      carry-in to nibble 0
// - out_valid  out  1      sum and out_carry are valid
// - out_ready  in   1      consumer accepts the result
// - sum        out  WIDTH  a + b + carry, modulo 2^WIDTH
// - out_carry  out  1      carry out of the MSB nibble
// - ovf        out  1      signed overflow (only with CLA_SERIAL_OVF_EN)
// BEHAVIOUR
// - One clock and one reset: clk, and rst (synchronous, active-high). No asynchronous logic.
// - Reset values: state IDLE, in_ready 1, out_valid 0, sum 0, out_carry 0, ovf 0, nibble index 0, carry register 0.
// - Reset asserted mid-operation aborts the add. No result is produced and the block is in IDLE the cycle after.
// - FSM states: IDLE, BUSY, DONE.
//   - IDLE: in_ready = 1. The accept is in_valid & in_ready sampled at edge k.
//   - On accept: capture a, b and carry into internal registers, set idx = 0, go to BUSY.
//   - BUSY: the slice takes nibble 0 of the operand shift registers and the carry register.
//     - Each edge: shift the slice sum into the top of the sum shift register and shift the operands right by 4.
//     - Each edge: carry register <= slice carry out, idx++.
//     - When idx == NIB-1, that edge also loads sum, out_carry (and ovf) from the final values and goes to DONE.
//   - DONE: out_valid = 1 and outputs held stable. When out_ready is sampled high, go to IDLE.
//     - out_valid drops and in_ready rises after that edge.
// - Handshake rules:
//   - in_ready = (state == IDLE) and out_valid = (state == DONE), both decoded from the registered state.
//   - a, b and carry are ignored outside an accept edge. in_valid held during BUSY/DONE is not consumed.
//   - out_ready outside DONE is ignored. No simultaneous accept and result in the same cycle.
// - Latency:
//   - Accept at edge k -> out_valid high after edge k+NIB.
//   - With out_ready held at 1, the earliest next accept is edge k+NIB+2, so throughput is 1 add per NIB+2 cycles.
// - Arithmetic:
//   - {out_carry, sum} = a + b + carry exactly (WIDTH+1 bits, unsigned).
//   - Wrap-around is modulo 2^WIDTH, with the excess in out_carry.
// - sum, out_carry and ovf hold the last completed result through IDLE until the next completion overwrites them.
// - idx width is clog2(NIB), minimum 1 bit. For WIDTH=4 the block spends exactly one BUSY cycle.
// CONFIGURATION
// - CLA_SERIAL_OVF_EN defined:
//   - The ovf port exists. At capture, save the MSBs a[WIDTH-1] and b[WIDTH-1].
//   - ovf = (a_msb == b_msb) && (final sum[WIDTH-1] != a_msb). It is loaded together with sum and held with it.
// - CLA_SERIAL_OVF_EN not defined: the ovf port and the MSB capture registers are absent. All other behaviour is identical.
// TESTING (WIDTH=16 unless noted)
// - Reset:
//   - Assert rst 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, sum=0x0000, out_carry=0.
//   - No accept occurs while rst is high.
// - Full carry ripple:
//   - Accept a=0xFFFF, b=0x0001, carry=0 -> out_valid high exactly 4 edges later.
//   - Result: sum=0x0000, out_carry=1, ovf=0.
// - Carry-in and overflow:
//   - a=0x7FFF, b=0x0000, carry=1 -> sum=0x8000, out_carry=0, ovf=1 (with CLA_SERIAL_OVF_EN).
// - Backpressure:
//   - a=0x1234, b=0x4321, carry=0, with out_ready=0 for 5 cycles in DONE.
//   - sum=0x5555 held stable, out_valid stays 1 and in_ready stays 0.
//   - Raise out_ready -> IDLE the next cycle.
// - Abort: accept a=0xFFFF, b=0xFFFF, then assert rst after 2 BUSY cycles.
//   - out_valid never rises and sum stays 0x0000.
//   - A following add 0x0003+0x0004 gives sum=0x0007.
// - Back-to-back with out_ready=1 and in_valid=1 held:
//   - Adds 0x00FF+0x0001 then 0x8000+0x8000 give 0x0100/cout 0 then 0x0000/cout 1.
//   - The two accepts are spaced NIB+2 = 6 cycles apart.
//   - Repeat with WIDTH=4: 0xF+0x1 -> sum 0x0, cout 1, latency 1.

Source files
------------

// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder reusing one 4-bit carry-lookahead slice per clock, LS nibble first.
// Define CLA_SERIAL_OVF_EN to add the signed-overflow output (ovf).
module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CLA_SERIAL_OVF_EN
  output logic             out_carry,
  output logic             ovf
`else
  output logic             out_carry
`endif
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // 4-bit carry-lookahead slice: returns {carry_out, sum[3:0]}
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  logic [1:0]       state_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [IDXW-1:0]  idx_r;
  logic             cy_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] sum_r;
  logic             out_carry_r;
  logic [4:0]       slice_s;
  logic [WIDTH-1:0] next_acc_s;
`ifdef CLA_SERIAL_OVF_EN
  logic             a_msb_r;
  logic             b_msb_r;
  logic             ovf_r;
`endif

  // Slice works on the low nibble of the operand shift registers and the carry register
  always_comb begin
    slice_s = cla4(a_sh_r[3:0], b_sh_r[3:0], cy_r);
  end

  // New slice nibble enters at the top of the sum shift register
  generate
    if (NIB == 1) begin : g_single
      assign next_acc_s = slice_s[3:0];
    end else begin : g_multi
      assign next_acc_s = {slice_s[3:0], acc_r[WIDTH-1:4]};
    end
  endgenerate

  // Control FSM, operand/sum shift registers and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      idx_r       <= '0;
      cy_r        <= 1'b0;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      acc_r       <= '0;
      sum_r       <= '0;
      out_carry_r <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
      a_msb_r     <= 1'b0;
      b_msb_r     <= 1'b0;
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            a_sh_r     <= a;
            b_sh_r     <= b;
            cy_r       <= carry;
            idx_r      <= '0;
            state_r    <= ST_BUSY;
            in_ready_r <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
            a_msb_r    <= a[WIDTH-1];
            b_msb_r    <= b[WIDTH-1];
`endif
          end
        end
        ST_BUSY: begin
          a_sh_r <= a_sh_r >> 3'd4;
          b_sh_r <= b_sh_r >> 3'd4;
          acc_r  <= next_acc_s;
          cy_r   <= slice_s[4];
          idx_r  <= idx_r + IDXW'(1);
          // Last nibble: publish the completed result in the same edge
          if (idx_r == IDX_LAST) begin
            sum_r       <= next_acc_s;
            out_carry_r <= slice_s[4];
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
`ifdef CLA_SERIAL_OVF_EN
            ovf_r       <= (a_msb_r == b_msb_r) && (slice_s[3] != a_msb_r);
`endif
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign out_carry = out_carry_r;
`ifdef CLA_SERIAL_OVF_EN
  assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Self-checking bench for cla_nibble_serial_adder: WIDTH=16 and WIDTH=4 instances against an arithmetic model.
// Overflow checks are active when CLA_SERIAL_OVF_EN is defined.
module tb_cla_nibble_serial_adder;

  localparam int NIB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, carry, out_valid, out_ready, out_carry;
  logic [15:0] a, b, sum;
  logic        in_valid4, in_ready4, carry4, out_valid4, out_ready4, out_carry4;
  logic [3:0]  a4, b4, sum4;
`ifdef CLA_SERIAL_OVF_EN
  logic        ovf, ovf4;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cla_nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry(carry), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum),
`ifdef CLA_SERIAL_OVF_EN
    .ovf(ovf),
`endif
    .out_carry(out_carry)
  );

  cla_nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .carry(carry4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4),
`ifdef CLA_SERIAL_OVF_EN
    .ovf(ovf4),
`endif
    .out_carry(out_carry4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model16(input logic [15:0] x, input logic [15:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {16'd0, c};
  endfunction

  function automatic logic ovf_model(input logic [15:0] x, input logic [15:0] y, input logic c);
    int sx, sy, s;
    sx = int'($signed(x));
    sy = int'($signed(y));
    s  = sx + sy + int'(c);
    return (s > 32767) || (s < -32768);
  endfunction

  // One 16-bit transaction with 'hold' cycles of backpressure in DONE
  task automatic do_add(input logic [15:0] av, input logic [15:0] bv, input logic cv, input int hold);
    logic [16:0] exp;
    int lat;
    exp = model16(av, bv, cv);
    @(negedge clk);
    in_valid = 1'b1; a = av; b = bv; carry = cv;
    @(negedge clk);
    check("accept_in_ready", in_ready, 0);
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); carry = 1'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, NIB);
    check("sum", sum, exp[15:0]);
    check("out_carry", out_carry, exp[16]);
`ifdef CLA_SERIAL_OVF_EN
    check("ovf", ovf, ovf_model(av, bv, cv));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", sum, exp[15:0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("idle_sum_held", sum, exp[15:0]);
    out_ready = 1'b0;
  endtask

  // One 4-bit transaction on the narrow instance
  task automatic add4(input logic [3:0] av, input logic [3:0] bv, input logic cv);
    logic [4:0] exp;
    int lat;
    exp = {1'b0, av} + {1'b0, bv} + {4'd0, cv};
    @(negedge clk);
    in_valid4 = 1'b1; a4 = av; b4 = bv; carry4 = cv;
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (out_valid4 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w4_latency", lat, 1);
    check("w4_sum", sum4, exp[3:0]);
    check("w4_out_carry", out_carry4, exp[4]);
    out_ready4 = 1'b1;
    @(negedge clk);
    check("w4_in_ready", in_ready4, 1);
    out_ready4 = 1'b0;
  endtask

  initial begin
    logic [16:0] exp1, exp2;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; a = 16'h1111; b = 16'h2222; carry = 1'b1;
    in_valid4 = 1'b1; out_ready4 = 1'b0; a4 = 4'h3; b4 = 4'h4; carry4 = 1'b0;

    // Reset with in_valid held
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 16'h0000);
    check("rst_out_carry", out_carry, 0);
    check("rst_w4_in_ready", in_ready4, 1);
`ifdef CLA_SERIAL_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    in_valid = 1'b0; in_valid4 = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("post_rst_no_accept", in_ready, 1);

    // Full carry ripple, then carry-in into signed overflow
    do_add(16'hFFFF, 16'h0001, 1'b0, 0);
    do_add(16'h7FFF, 16'h0000, 1'b1, 0);

    // Backpressure
    do_add(16'h1234, 16'h4321, 1'b0, 5);

    // Abort mid-operation
    @(negedge clk);
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; carry = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_out_valid", out_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_sum", sum, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_result", out_valid, 0);
    end
    do_add(16'h0003, 16'h0004, 1'b0, 0);

    // Back-to-back with in_valid and out_ready held high
    exp1 = model16(16'h00FF, 16'h0001, 1'b0);
    exp2 = model16(16'h8000, 16'h8000, 1'b0);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h00FF; b = 16'h0001; carry = 1'b0;
    @(negedge clk);
    a = 16'h8000; b = 16'h8000;
    for (int t = 1; t <= 2 * NIB + 2; t++) begin
      @(negedge clk);
      check("b2b_out_valid", out_valid, (t == NIB) || (t == 2 * NIB + 2));
      check("b2b_in_ready", in_ready, t == NIB + 1);
      if (t == NIB) begin
        check("b2b_sum1", sum, exp1[15:0]);
        check("b2b_cout1", out_carry, exp1[16]);
      end
      if (t == 2 * NIB + 2) begin
        check("b2b_sum2", sum, exp2[15:0]);
        check("b2b_cout2", out_carry, exp2[16]);
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_final_in_ready", in_ready, 1);
    out_ready = 1'b0;

    // Randomized transactions with random backpressure
    for (int i = 0; i < 8; i++)
      do_add(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(3, 0)));

    // Narrow instance: single BUSY cycle
    add4(4'hF, 4'h1, 1'b0);
    for (int i = 0; i < 6; i++)
      add4(4'($urandom), 4'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
